// File: rtl/vga_panel_pkg.sv
// Shared constants and types for the VGA text-panel string path.
// A panel string is 13 ASCII characters, with character 0 in the top byte.
package vga_panel_pkg;

   localparam int unsigned CHAR_COUNT   = 13;
   localparam int unsigned STRING_W     = 104;
   localparam logic [7:0]  DEFAULT_CHAR = 8'h20;

   typedef logic [STRING_W-1:0] panel_string_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PENDING,
      ST_HOLD
   } sched_state_t;

   function automatic panel_string_t fill_string(input logic [7:0] ch);
      return {CHAR_COUNT{ch}};
   endfunction

endpackage

// File: rtl/panel_string_scheduler_if.sv
// Request channels into the panel scheduler: a high-priority sys requester
// and a low-priority usr requester, each a valid/ready handshake with a string.
interface panel_string_scheduler_if;

   logic                        sys_valid;
   logic                        sys_ready;
   vga_panel_pkg::panel_string_t sys_string;
   logic                        usr_valid;
   logic                        usr_ready;
   vga_panel_pkg::panel_string_t usr_string;

   modport master (
      output sys_valid, sys_string, usr_valid, usr_string,
      input  sys_ready, usr_ready
   );

   modport slave (
      input  sys_valid, sys_string, usr_valid, usr_string,
      output sys_ready, usr_ready
   );

endinterface

// File: rtl/frame_tick_gen.sv
// One-cycle frame pulse, registered, following the rising edge of the
// pixel-position match; a match lasting several cycles yields one pulse.
module frame_tick_gen #(
   parameter int unsigned TICK_X = 0,
   parameter int unsigned TICK_Y = 480
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] pos_x,
   input  logic [9:0] pos_y,
   output logic       frame_tick
);

   logic match;
   logic match_q;

   always_comb match = (pos_x == 10'(TICK_X)) && (pos_y == 10'(TICK_Y));

   always_ff @(posedge clk) begin
      if (rst) begin
         match_q    <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         match_q    <= match;
         frame_tick <= match && !match_q;
      end
   end

endmodule

// File: rtl/panel_string_scheduler.sv
// Arbitrates sys/usr string requests onto the text panel, swapping the shown
// string only right after a frame tick and holding it for a minimum of frames.
module panel_string_scheduler #(
   parameter int unsigned MIN_HOLD_FRAMES = 30,
   parameter int unsigned FRAME_TICK_X    = 0,
   parameter int unsigned FRAME_TICK_Y    = 480,
   parameter logic [7:0]  DEFAULT_CHAR    = 8'h20
) (
   input  logic                         vga_clk,
   input  logic                         rst,
   input  logic [9:0]                   pos_x,
   input  logic [9:0]                   pos_y,
   panel_string_scheduler_if.slave      req,
   output vga_panel_pkg::panel_string_t disp_string,
   output logic                         owner,
   output logic                         frame_tick,
   output logic                         update
);

   import vga_panel_pkg::*;

   localparam panel_string_t DEFAULT_STRING = fill_string(DEFAULT_CHAR);

   sched_state_t  state, state_nxt;
   panel_string_t shadow, shadow_nxt, disp_nxt;
   logic          shadow_owner, shadow_owner_nxt, owner_nxt, update_nxt;
   logic [7:0]    hold_cnt, hold_nxt;
   logic          sys_rdy, usr_rdy, sys_xfer, usr_xfer;

   frame_tick_gen #(
      .TICK_X (FRAME_TICK_X),
      .TICK_Y (FRAME_TICK_Y)
   ) u_frame_tick (
      .clk        (vga_clk),
      .rst        (rst),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .frame_tick (frame_tick)
   );

   assign req.sys_ready = sys_rdy;
   assign req.usr_ready = usr_rdy;

   always_ff @(posedge vga_clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         shadow       <= DEFAULT_STRING;
         shadow_owner <= 1'b0;
         disp_string  <= DEFAULT_STRING;
         owner        <= 1'b0;
         update       <= 1'b0;
         hold_cnt     <= '0;
      end else begin
         state        <= state_nxt;
         shadow       <= shadow_nxt;
         shadow_owner <= shadow_owner_nxt;
         disp_string  <= disp_nxt;
         owner        <= owner_nxt;
         update       <= update_nxt;
         hold_cnt     <= hold_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      shadow_nxt       = shadow;
      shadow_owner_nxt = shadow_owner;
      disp_nxt         = disp_string;
      owner_nxt        = owner;
      update_nxt       = 1'b0;
      hold_nxt         = hold_cnt;
      sys_rdy          = 1'b0;
      usr_rdy          = 1'b0;

      // Only a usr-owned hold may be preempted, and only by sys.
      unique case (state)
         ST_IDLE: begin
            sys_rdy = 1'b1;
            usr_rdy = !req.sys_valid;
         end
         ST_HOLD:  sys_rdy = !owner;
         default: ;
      endcase
      if (rst) begin
         sys_rdy = 1'b0;
         usr_rdy = 1'b0;
      end

      sys_xfer = req.sys_valid && sys_rdy;
      usr_xfer = req.usr_valid && usr_rdy;

      // A tick coinciding with a transfer is deliberately left unused.
      unique case (state)
         ST_IDLE: begin
            if (sys_xfer) begin
               shadow_nxt       = req.sys_string;
               shadow_owner_nxt = 1'b1;
               state_nxt        = ST_PENDING;
            end else if (usr_xfer) begin
               shadow_nxt       = req.usr_string;
               shadow_owner_nxt = 1'b0;
               state_nxt        = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (frame_tick) begin
               disp_nxt   = shadow;
               owner_nxt  = shadow_owner;
               update_nxt = 1'b1;
               hold_nxt   = 8'(MIN_HOLD_FRAMES);
               state_nxt  = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (sys_xfer) begin
               shadow_nxt       = req.sys_string;
               shadow_owner_nxt = 1'b1;
               state_nxt        = ST_PENDING;
            end else if (frame_tick) begin
               if (hold_cnt <= 8'd1) begin
                  hold_nxt  = '0;
                  state_nxt = ST_IDLE;
               end else begin
                  hold_nxt = hold_cnt - 8'd1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_panel_string_scheduler.sv
// Randomized scoreboard bench for panel_string_scheduler: a frame-level
// reference model predicts readiness, ticks and displayed strings.
module tb_panel_string_scheduler;

   import vga_panel_pkg::*;

   localparam int unsigned HOLD  = 2;
   localparam int unsigned TX    = 0;
   localparam int unsigned TY    = 4;
   localparam int unsigned H_TOT = 8;
   localparam int unsigned V_TOT = 6;
   localparam panel_string_t DEF = {13{8'h20}};

   typedef struct packed {
      logic          o;
      panel_string_t s;
   } disp_t;

   logic          vga_clk = 1'b0;
   logic          rst     = 1'b1;
   logic [9:0]    pos_x   = '0;
   logic [9:0]    pos_y   = '0;
   panel_string_t disp_string;
   logic          owner, frame_tick, update;

   panel_string_scheduler_if bus();

   panel_string_scheduler #(
      .MIN_HOLD_FRAMES (HOLD),
      .FRAME_TICK_X    (TX),
      .FRAME_TICK_Y    (TY),
      .DEFAULT_CHAR    (8'h20)
   ) dut (
      .vga_clk     (vga_clk),
      .rst         (rst),
      .pos_x       (pos_x),
      .pos_y       (pos_y),
      .req         (bus.slave),
      .disp_string (disp_string),
      .owner       (owner),
      .frame_tick  (frame_tick),
      .update      (update)
   );

   always #5 vga_clk = ~vga_clk;

   int checks = 0;
   int errors = 0;

   disp_t sb_q[$];

   // reference model: a string waiting for a frame, frames left to hold, who is shown
   bit            m_pend = 0;
   panel_string_t m_pend_str;
   bit            m_pend_own;
   int            m_hold_left = 0;
   bit            m_shown_own = 0;
   bit            m_tick = 0;
   bit            m_match_prev = 0;

   bit            sys_req = 0, usr_req = 0, rnd_on = 0, arm_usr_tick = 0;
   panel_string_t sys_str = DEF, usr_str = DEF;
   int unsigned   px = 0, py = 0;

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic checkw(input string name, input panel_string_t act, input panel_string_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      errors++;
      $display("FAIL %s_timeout actual=expired required=done", name);
   endtask

   function automatic panel_string_t rand_str();
      panel_string_t s;
      for (int i = 0; i < 13; i++) s[i*8 +: 8] = 8'(32'h41 + $urandom_range(25));
      return s;
   endfunction

   function automatic bit model_idle();
      return !m_pend && (m_hold_left == 0) && !sys_req && !usr_req;
   endfunction

   // One clock: check the tick, drive inputs, check ready, advance the model.
   task automatic step(input bit do_rst);
      bit match_now, holding, exp_sr, exp_ur, acc_sys, acc_usr;
      @(negedge vga_clk);
      check1("frame_tick", frame_tick, m_tick);
      if (rnd_on) begin
         if (!sys_req && $urandom_range(40) == 0) begin sys_req = 1; sys_str = rand_str(); end
         if (!usr_req && $urandom_range(10) == 0) begin usr_req = 1; usr_str = rand_str(); end
      end
      if (arm_usr_tick && m_tick && model_idle()) begin
         usr_req = 1; usr_str = rand_str(); arm_usr_tick = 0;
      end
      if ($urandom_range(7) != 0) begin
         px++;
         if (px == H_TOT) begin px = 0; py = (py + 1) % V_TOT; end
      end
      pos_x = 10'(px); pos_y = 10'(py);
      rst = do_rst;
      bus.sys_valid = sys_req; bus.sys_string = sys_str;
      bus.usr_valid = usr_req; bus.usr_string = usr_str;
      #1;
      match_now = (px == TX) && (py == TY);
      if (do_rst) begin
         check1("sys_ready_rst", bus.sys_ready, 1'b0);
         check1("usr_ready_rst", bus.usr_ready, 1'b0);
         m_pend = 0; m_hold_left = 0; m_shown_own = 0;
         m_tick = 0; m_match_prev = 0;
         sb_q.delete();
      end else begin
         holding = (m_hold_left > 0);
         exp_sr  = !m_pend && !(holding && m_shown_own);
         exp_ur  = !m_pend && !holding && !sys_req;
         check1("sys_ready", bus.sys_ready, exp_sr);
         check1("usr_ready", bus.usr_ready, exp_ur);
         acc_sys = sys_req && exp_sr;
         acc_usr = !acc_sys && usr_req && exp_ur;
         if (acc_sys) begin
            m_pend = 1; m_pend_str = sys_str; m_pend_own = 1; m_hold_left = 0; sys_req = 0;
         end else if (acc_usr) begin
            m_pend = 1; m_pend_str = usr_str; m_pend_own = 0; usr_req = 0;
         end else if (m_pend && m_tick) begin
            sb_q.push_back('{o: m_pend_own, s: m_pend_str});
            m_shown_own = m_pend_own; m_hold_left = HOLD; m_pend = 0;
         end else if (holding && m_tick) begin
            m_hold_left--;
         end
         m_tick = match_now && !m_match_prev;
         m_match_prev = match_now;
      end
   endtask

   task automatic monitor();
      panel_string_t cur_s;
      logic          cur_o;
      disp_t         e;
      logic          r;
      cur_s = DEF; cur_o = 1'b0;
      forever begin
         @(posedge vga_clk);
         r = rst;
         #2;
         if (r) begin cur_s = DEF; cur_o = 1'b0; end
         if (update === 1'b1) begin
            if (sb_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_update actual=1 required=0 disp=%h", disp_string);
            end else begin
               e = sb_q.pop_front();
               cur_s = e.s; cur_o = e.o;
            end
         end else begin
            check1("update_quiet", update, 1'b0);
         end
         checkw("disp_string", disp_string, cur_s);
         check1("owner", owner, cur_o);
      end
   endtask

   initial begin
      int n;
      bus.sys_valid = 0; bus.usr_valid = 0;
      bus.sys_string = DEF; bus.usr_string = DEF;
      fork
         monitor();
      join_none
      @(posedge vga_clk);
      for (int i = 0; i < 3; i++) step(1);
      for (int i = 0; i < 60; i++) step(0);

      usr_str = "SONG:LITTLEST"; usr_req = 1;
      n = 0; while (!model_idle() && n < 400) begin step(0); n++; end
      if (!model_idle()) timeout("usr_single");

      sys_req = 1; sys_str = rand_str(); usr_req = 1; usr_str = rand_str();
      n = 0; while (!model_idle() && n < 800) begin step(0); n++; end
      if (!model_idle()) timeout("sys_usr_same_cycle");

      usr_req = 1; usr_str = rand_str();
      n = 0; while (!(m_hold_left == HOLD && !m_pend) && n < 400) begin step(0); n++; end
      if (!(m_hold_left == HOLD && !m_pend)) timeout("usr_into_hold");
      sys_req = 1; sys_str = rand_str();
      n = 0; while (!model_idle() && n < 800) begin step(0); n++; end
      if (!model_idle()) timeout("sys_preempt");

      arm_usr_tick = 1;
      n = 0; while ((arm_usr_tick || !model_idle()) && n < 800) begin step(0); n++; end
      if (arm_usr_tick || !model_idle()) timeout("xfer_on_tick");

      usr_req = 1; usr_str = rand_str();
      n = 0; while (!m_pend && n < 20) begin step(0); n++; end
      if (!m_pend) timeout("usr_pending");
      step(1); step(1);
      for (int i = 0; i < 200; i++) step(0);

      rnd_on = 1;
      for (int i = 0; i < 3000; i++) step(0);
      rnd_on = 0;
      n = 0; while (!(model_idle() && sb_q.size() == 0) && n < 1000) begin step(0); n++; end
      if (!(model_idle() && sb_q.size() == 0)) timeout("drain");
      for (int i = 0; i < 5; i++) step(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
